// File: rtl/ifu_prefetch.sv
// Instruction fetch with a small prefetch FIFO between the sync ROM and decode.
// Optional IFU_BYPASS_EN: forwards a ROM response straight to decode when the FIFO is empty.
module ifu_prefetch #(
  parameter logic [63:0] RESET_PC   = 64'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        rom_req_o,
  output logic [63:0] rom_addr_o,
  input  logic [31:0] rom_inst_i,
  input  logic        jump_en_i,
  input  logic [63:0] jump_addr_i,
  input  logic        hold_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [63:0] inst_addr_o
);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL_C  = CW'(FIFO_DEPTH);
  localparam logic [CW:0]   DEPTH_C = (CW+1)'(FIFO_DEPTH);

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
  } entry_t;

  entry_t        mem_q [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [63:0]   fetch_pc_q, fetch_pc_d, req_pc_q;
  logic          inflight_q, squash_q, squash_d;
  logic [CW:0]   occ;
  logic          resp_vld, head_vld, consume, push, pop;
  entry_t        head;
  logic          unused_jump_lsb;

  assign unused_jump_lsb = ^jump_addr_i[1:0];

  // Occupancy counts the in-flight slot so a full FIFO never overflows.
  assign occ        = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
  assign rom_req_o  = !rst && !jump_en_i && (occ < DEPTH_C);
  assign rom_addr_o = rst ? RESET_PC : fetch_pc_q;

  assign resp_vld = inflight_q && !squash_q;
  assign head_vld = (count_q != '0);
  assign head     = mem_q[rd_ptr_q];
  assign consume  = inst_valid_o && !hold_i && !jump_en_i;
  assign pop      = consume && head_vld;

`ifdef IFU_BYPASS_EN
  logic byp;
  assign byp          = resp_vld && !head_vld;
  assign inst_valid_o = !rst && (head_vld || byp);
  assign inst_o       = !inst_valid_o ? NOP_INST : (head_vld ? head.inst : rom_inst_i);
  assign inst_addr_o  = !inst_valid_o ? 64'd0    : (head_vld ? head.pc   : req_pc_q);
  // A bypassed response consumed this cycle never enters the FIFO.
  assign push         = !rst && !jump_en_i && resp_vld && !(byp && consume);
`else
  assign inst_valid_o = !rst && head_vld;
  assign inst_o       = inst_valid_o ? head.inst : NOP_INST;
  assign inst_addr_o  = inst_valid_o ? head.pc   : 64'd0;
  assign push         = !rst && !jump_en_i && resp_vld;
`endif

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    squash_d   = 1'b0;
    if (jump_en_i) begin
      fetch_pc_d = {jump_addr_i[63:2], 2'b00};
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      squash_d   = inflight_q;
    end else begin
      if (rom_req_o) fetch_pc_d = fetch_pc_q + 64'd4;
      if (push)      wr_ptr_d   = wr_ptr_q + PW'(1);
      if (pop)       rd_ptr_d   = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      inflight_q <= 1'b0;
      squash_q   <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      inflight_q <= rom_req_o;
      squash_q   <= squash_d;
      if (rom_req_o) req_pc_q <= fetch_pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{pc: req_pc_q, inst: rom_inst_i};
  end

  always_ff @(posedge clk) begin
    if (push) assert (count_q != FULL_C);
  end
endmodule

// File: tb/tb_ifu_prefetch.sv
// Bench for ifu_prefetch: ROM[i]=i model, scoreboard of expected fetch PCs per stream.
module tb_ifu_prefetch;
  localparam logic [63:0] RESET_PC = 64'h0;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] NOP      = 32'h0000_0013;
`ifdef IFU_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rom_req_o;
  logic [63:0] rom_addr_o;
  logic [31:0] rom_inst_i = 32'h0;
  logic        jump = 1'b0;
  logic [63:0] jaddr = 64'h0;
  logic        hold = 1'b0;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [63:0] inst_addr_o;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];
  bit sb_en = 1'b0;

  ifu_prefetch #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH), .NOP_INST(NOP)) dut (
    .clk(clk), .rst(rst), .rom_req_o(rom_req_o), .rom_addr_o(rom_addr_o),
    .rom_inst_i(rom_inst_i), .jump_en_i(jump), .jump_addr_i(jaddr), .hold_i(hold),
    .inst_valid_o(inst_valid_o), .inst_o(inst_o), .inst_addr_o(inst_addr_o)
  );

  always #5 clk = ~clk;

  // Synchronous ROM: word i holds value i, one cycle of latency.
  always @(posedge clk) if (rom_req_o) rom_inst_i <= rom_addr_o[33:2];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_restart(input logic [63:0] pc);
    exp_q.delete();
    for (int i = 0; i < 128; i++) exp_q.push_back(pc + 64'(4 * i));
  endtask

  // Every presented instruction must be the next one of the current stream.
  always @(negedge clk) begin
    logic [63:0] e;
    if (sb_en && !rst && inst_valid_o) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL stream_underrun got addr %h", inst_addr_o);
      end else begin
        e = exp_q[0];
        if (inst_addr_o !== e || inst_o !== e[33:2]) begin
          errors++;
          $display("FAIL stream got %h:%h want %h:%h", inst_addr_o, inst_o, e, e[33:2]);
        end
        if (!hold && !jump) void'(exp_q.pop_front());
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1; hold = 1'b0; jump = 1'b0;
    tick(); tick();
    @(negedge clk);
    checks++; if (rom_req_o !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", rom_req_o); end
    checks++; if (rom_addr_o !== RESET_PC) begin errors++; $display("FAIL reset_addr got %h want %h", rom_addr_o, RESET_PC); end
    checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", inst_valid_o); end
    checks++; if (inst_o !== NOP) begin errors++; $display("FAIL reset_inst got %h want %h", inst_o, NOP); end
    checks++; if (inst_addr_o !== 64'd0) begin errors++; $display("FAIL reset_iaddr got %h want 0", inst_addr_o); end
    tick();
  endtask

  task automatic test_startup();
    rst = 1'b0;
    sb_restart(RESET_PC);
    sb_en = 1'b1;
    for (int k = 0; k <= LAT; k++) begin
      @(negedge clk);
      checks++;
      if (rom_req_o !== 1'b1 || rom_addr_o !== RESET_PC + 64'(4 * k)) begin
        errors++; $display("FAIL start_req c%0d got %b/%h want 1/%h", k, rom_req_o, rom_addr_o, RESET_PC + 64'(4 * k));
      end
      checks++;
      if (inst_valid_o !== logic'(k == LAT)) begin
        errors++; $display("FAIL start_valid c%0d got %b want %b", k, inst_valid_o, k == LAT);
      end
      tick();
    end
  endtask

  task automatic test_stream();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checks++; if (inst_valid_o !== 1'b1) begin errors++; $display("FAIL stream_gap c%0d got %b want 1", k, inst_valid_o); end
      tick();
    end
  endtask

  task automatic test_hold();
    logic [63:0] h;
    hold = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks++; if (inst_valid_o !== 1'b1) begin errors++; $display("FAIL hold_valid c%0d got %b want 1", k, inst_valid_o); end
      if (k >= 6) begin
        checks++; if (rom_req_o !== 1'b0) begin errors++; $display("FAIL hold_full_req c%0d got %b want 0", k, rom_req_o); end
      end
      if (k == 9) begin
        h = exp_q[0] + 64'(4 * DEPTH);
        checks++; if (rom_addr_o !== h) begin errors++; $display("FAIL hold_fetch_pc got %h want %h", rom_addr_o, h); end
      end
      tick();
    end
    hold = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checks++; if (inst_valid_o !== 1'b1) begin errors++; $display("FAIL release_gap c%0d got %b want 1", k, inst_valid_o); end
      tick();
    end
  endtask

  // Three entries queued and one in flight when the jump lands.
  task automatic test_jump();
    rst = 1'b1; hold = 1'b1;
    tick();
    rst = 1'b0;
    sb_restart(RESET_PC);
    for (int k = 0; k < 4; k++) tick();
    jump = 1'b1; jaddr = 64'h106;
    @(negedge clk);
    checks++; if (rom_req_o !== 1'b0) begin errors++; $display("FAIL jump_req got %b want 0", rom_req_o); end
    tick();
    jump = 1'b0; hold = 1'b0;
    sb_restart(64'h104);
    for (int k = 1; k <= LAT + 1; k++) begin
      @(negedge clk);
      if (k == 1) begin
        checks++;
        if (rom_req_o !== 1'b1 || rom_addr_o !== 64'h104) begin
          errors++; $display("FAIL jump_target_req got %b/%h want 1/104", rom_req_o, rom_addr_o);
        end
      end
      checks++;
      if (inst_valid_o !== logic'(k == LAT + 1)) begin
        errors++; $display("FAIL jump_valid N+%0d got %b want %b", k, inst_valid_o, k == LAT + 1);
      end
      tick();
    end
    for (int k = 0; k < 4; k++) tick();
  endtask

  task automatic test_jump_hold_full();
    hold = 1'b1;
    for (int k = 0; k < 8; k++) tick();
    jump = 1'b1; jaddr = 64'h200;
    @(negedge clk);
    checks++; if (inst_valid_o !== 1'b1) begin errors++; $display("FAIL jhold_pre got %b want 1", inst_valid_o); end
    tick();
    jump = 1'b0;
    sb_restart(64'h200);
    @(negedge clk);
    checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL jhold_flush got %b want 0", inst_valid_o); end
    checks++;
    if (rom_req_o !== 1'b1 || rom_addr_o !== 64'h200) begin
      errors++; $display("FAIL jhold_req got %b/%h want 1/200", rom_req_o, rom_addr_o);
    end
    hold = 1'b0;
    for (int k = 0; k < 6; k++) tick();
  endtask

  task automatic test_back_to_back();
    jump = 1'b1; jaddr = 64'h300;
    @(negedge clk);
    checks++; if (rom_req_o !== 1'b0) begin errors++; $display("FAIL b2b_req0 got %b want 0", rom_req_o); end
    tick();
    jaddr = 64'h403;
    @(negedge clk);
    checks++; if (rom_req_o !== 1'b0) begin errors++; $display("FAIL b2b_req1 got %b want 0", rom_req_o); end
    tick();
    jump = 1'b0;
    sb_restart(64'h400);
    for (int k = 1; k <= LAT + 1; k++) begin
      @(negedge clk);
      if (k == 1) begin
        checks++;
        if (rom_req_o !== 1'b1 || rom_addr_o !== 64'h400) begin
          errors++; $display("FAIL b2b_target got %b/%h want 1/400", rom_req_o, rom_addr_o);
        end
      end
      checks++;
      if (inst_valid_o !== logic'(k == LAT + 1)) begin
        errors++; $display("FAIL b2b_valid N+%0d got %b want %b", k, inst_valid_o, k == LAT + 1);
      end
      tick();
    end
    for (int k = 0; k < 4; k++) tick();
  endtask

  // Reset together with a jump: reset wins and the stream restarts at RESET_PC.
  task automatic test_reset_mid();
    rst = 1'b1; jump = 1'b1; jaddr = 64'h700;
    @(negedge clk);
    checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL rmid_valid got %b want 0", inst_valid_o); end
    checks++; if (rom_req_o !== 1'b0) begin errors++; $display("FAIL rmid_req got %b want 0", rom_req_o); end
    checks++; if (inst_o !== NOP) begin errors++; $display("FAIL rmid_inst got %h want %h", inst_o, NOP); end
    tick();
    rst = 1'b0; jump = 1'b0;
    sb_restart(RESET_PC);
    for (int k = 0; k <= LAT + 6; k++) begin
      @(negedge clk);
      if (k == 0) begin
        checks++;
        if (rom_req_o !== 1'b1 || rom_addr_o !== RESET_PC) begin
          errors++; $display("FAIL rmid_restart got %b/%h want 1/%h", rom_req_o, rom_addr_o, RESET_PC);
        end
      end
      if (k <= LAT) begin
        checks++;
        if (inst_valid_o !== logic'(k == LAT)) begin
          errors++; $display("FAIL rmid_lat c%0d got %b want %b", k, inst_valid_o, k == LAT);
        end
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_startup();
    test_stream();
    test_hold();
    test_jump();
    test_jump_hold_full();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
